// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard scancode buffer.
package kbd_pkg;

  // Scancode prefix bytes
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Prefix decoder states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } pfx_state_e;

  // One stored FIFO entry: 10 bits
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_entry_t;

  // True when the byte is a prefix rather than a code byte
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_BRK);
  endfunction

endpackage

// File: rtl/kbd_buffer_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous strobe. Produces a one-cycle pulse per rising edge.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the strobe and remember the previous synchronized value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the value of
      // its predecessor from before this edge, giving a true shift chain.
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/kbd_buffer.sv
// Keyboard scancode buffer: decodes E0/F0 prefixes from the byte stream
// and queues code bytes with their prefix flags in a show-ahead FIFO.
module kbd_buffer
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_hit,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    q,
  output logic          q_ext,
  output logic          q_brk,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------
  // Byte event detection
  // ---------------------------------------------------------------
  logic byte_evt;

  sync_edge u_sync_edge (
    .clock   (clock),
    .reset   (reset),
    .async_i (ps2_hit),
    .rise_o  (byte_evt)
  );

  // ---------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------
  pfx_state_e state_q, state_d;
  logic       push_req;
  kbd_entry_t new_entry;

  // Prefix state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next prefix state and push request for code bytes
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    push_req       = 1'b0;
    new_entry.ext  = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
    new_entry.brk  = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
    new_entry.code = ps2_data;

    if (clr) begin
      state_d = ST_IDLE;
    end else if (byte_evt) begin
      if (ps2_data == PFX_EXT) begin
        state_d = ST_EXT;
      end else if (ps2_data == PFX_BRK) begin
        unique case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXTBRK;
          default: state_d = state_q;
        endcase
      end else begin
        // Code byte: queue it and return to IDLE even if it gets dropped
        push_req = !is_prefix(ps2_data);
        state_d  = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          full;
  logic          is_empty;
  logic          do_pop;
  logic          do_push;

  assign full     = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign do_pop   = rd & ~is_empty & ~clr;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_push  = push_req & (~full | do_pop);

  // Next pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push_req && full && !do_pop) ovf_d = 1'b1;
    end
  end

  // FIFO control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------
  kbd_entry_t mem_q [DEPTH];

  // Write the incoming entry at the tail
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; stale entries are never visible because
    // the head output is masked while empty and pointers are reset.
    if (do_push) mem_q[wr_ptr_q] <= new_entry;
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  kbd_entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign q        = is_empty ? 8'h00 : head.code;
  assign q_ext    = is_empty ? 1'b0  : head.ext;
  assign q_brk    = is_empty ? 1'b0  : head.brk;
  assign empty    = is_empty;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_kbd_buffer.sv
// Scoreboard testbench for kbd_buffer: stimulus queues expected entries,
// a monitor compares the head whenever a pop is presented.
module tb_kbd_buffer;
  import kbd_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    ps2_data;
  logic          ps2_hit;
  logic          rd;
  logic          clr;
  logic [7:0]    q;
  logic          q_ext;
  logic          q_brk;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  kbd_entry_t exp_q[$];
  logic       ovf_exp = 1'b0;

  kbd_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .rd       (rd),
    .clr      (clr),
    .q        (q),
    .q_ext    (q_ext),
    .q_brk    (q_brk),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: whenever a pop is presented on a non-empty FIFO, compare head
  always @(negedge clock) begin
    if (!reset && rd && !empty) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got=%0h want=none at %0t", {q_ext, q_brk, q}, $time);
      end else begin
        kbd_entry_t e;
        e = exp_q.pop_front();
        check("pop_head", {22'd0, q_ext, q_brk, q}, {22'd0, e.ext, e.brk, e.code});
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // One byte on the keyboard side; with_rd overlaps a pop with the push edge
  task automatic hit_byte(input logic [7:0] b, input bit with_rd);
    @(posedge clock); #1;
    ps2_data = b;
    ps2_hit  = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    if (with_rd) rd = 1'b1;
    @(posedge clock); #1;
    rd      = 1'b0;
    ps2_hit = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic send_prefix(input logic [7:0] b);
    hit_byte(b, 1'b0);
  endtask

  task automatic send_code(input logic [7:0] b, input logic ext, input logic brk, input bit with_rd);
    kbd_entry_t e;
    hit_byte(b, with_rd);
    e.ext  = ext;
    e.brk  = brk;
    e.code = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else                      ovf_exp = 1'b1;
  endtask

  task automatic pop();
    @(posedge clock); #1;
    rd = 1'b1;
    @(posedge clock); #1;
    rd = 1'b0;
  endtask

  task automatic flush();
    @(posedge clock); #1;
    clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ps2_data = 8'h00;
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_q",     {21'd0, q_ext, q_brk, q, 1'b0}, 32'd0);
    reset = 1'b0;

    // Basic push with exact 3-edge latency
    @(posedge clock); #1;
    ps2_data = 8'h1C;
    ps2_hit  = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("lat_edge2_empty", 32'(empty), 32'd1);
    @(posedge clock); #1;
    check("lat_edge3_count", 32'(count), 32'd1);
    check("basic_empty", 32'(empty), 32'd0);
    check("basic_q",     32'(q), 32'h1C);
    check("basic_flags", {30'd0, q_ext, q_brk}, 32'd0);
    exp_q.push_back('{ext: 1'b0, brk: 1'b0, code: 8'h1C});
    ps2_hit = 1'b0;
    repeat (3) @(posedge clock);
    pop();
    check("basic_pop_empty", 32'(empty), 32'd1);
    check("basic_pop_q",     32'(q), 32'h00);

    // Prefix decoding
    send_prefix(PFX_EXT);
    send_prefix(PFX_BRK);
    send_code(8'h75, 1'b1, 1'b1, 1'b0);
    check("pfx_count", 32'(count), 32'd1);
    check("pfx_q",     32'(q), 32'h75);
    check("pfx_flags", {30'd0, q_ext, q_brk}, 32'd3);
    send_code(8'h75, 1'b0, 1'b0, 1'b0);
    check("pfx_count2", 32'(count), 32'd2);
    pop();
    pop();
    check("pfx_drained", 32'(empty), 32'd1);

    // Break-only prefix
    send_prefix(PFX_BRK);
    send_code(8'h29, 1'b0, 1'b1, 1'b0);
    pop();

    // Overflow: 17 code bytes, no reads
    for (int i = 0; i < 17; i++) send_code(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  32'(q), 32'h20);
    // Push with rd while full: both happen, count stays at DEPTH
    send_code(8'h40, 1'b0, 1'b0, 1'b1);
    check("full_rd_count", 32'(count), 32'd16);
    check("full_rd_head",  32'(q), 32'h21);
    flush();
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_q",     32'(q), 32'h00);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) send_code(8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
    check("sim5_pre", 32'(count), 32'd5);
    send_code(8'h36, 1'b0, 1'b0, 1'b1);
    check("sim5_count", 32'(count), 32'd5);
    check("sim5_head",  32'(q), 32'h32);
    for (int i = 0; i < 5; i++) pop();
    check("sim5_drain", 32'(count), 32'd0);
    // Push with rd while empty: push only
    send_code(8'h41, 1'b0, 1'b0, 1'b1);
    check("sim_empty_count", 32'(count), 32'd1);
    check("sim_empty_q",     32'(q), 32'h41);
    pop();
    // rd while empty is ignored
    pop();
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_q",     32'(q), 32'h00);
    send_code(8'h42, 1'b0, 1'b0, 1'b0);
    check("rd_empty_ptr", 32'(q), 32'h42);
    pop();

    // Reset between E0 and the code byte
    send_code(8'h11, 1'b0, 1'b0, 1'b0);
    send_prefix(PFX_EXT);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_q",     32'(q), 32'h00);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    send_code(8'h6B, 1'b0, 1'b0, 1'b0);
    check("mid_rst_code", 32'(q), 32'h6B);
    check("mid_rst_ext",  32'(q_ext), 32'd0);
    pop();

    // Reset mid-byte discards the in-flight event
    @(posedge clock); #1;
    ps2_data = 8'h22;
    ps2_hit  = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b1;
    ps2_hit = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("inflight_count", 32'(count), 32'd0);

    // Wrap-around with interleaved pops
    for (int i = 0; i < 40; i++) begin
      logic ext;
      logic brk;
      ext = (i % 3 == 0);
      brk = (i % 4 == 1);
      if (ext) send_prefix(PFX_EXT);
      if (brk) send_prefix(PFX_BRK);
      send_code(8'(i * 5 + 1), ext, brk, (i % 2 == 1));
      if (i % 3 == 2) pop();
      check("wrap_count", 32'(count), 32'(exp_q.size()));
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (exp_q.size() > 0) pop();
    end
    check("wrap_empty",  32'(empty), 32'd1);
    check("wrap_ovf",    32'(overflow), 32'(ovf_exp));
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_buffer.md
KBD_BUFFER -- requirements
Module: kbd_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, 4..256.
REQ-002 SHALL have parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ps2_data, input, 8, received byte from the keyboard controller; stable while ps2_hit is high and until the next byte.
REQ-006 SHALL have port ps2_hit, input, 1, new-byte indication; treated as asynchronous; a rising edge marks one new byte.
REQ-007 SHALL have port rd, input, 1, single-cycle pop strobe from the memory controller.
REQ-008 SHALL have port clr, input, 1, synchronous flush strobe.
REQ-009 SHALL have port q, output, 8, head scancode; show-ahead, no read latency.
REQ-010 SHALL have port q_ext, output, 1, head entry was preceded by an E0 prefix.
REQ-011 SHALL have port q_brk, output, 1, head entry was preceded by an F0 (release) prefix.
REQ-012 SHALL have port empty, output, 1, FIFO holds no entries.
REQ-013 SHALL have port count, output, AW+1, current number of entries, 0..DEPTH.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a code byte was dropped.

Function
REQ-015 SHALL pass ps2_hit through a 2-flop synchronizer and a rising-edge detector; byte event = sync2 high and previous sync2 low.
REQ-016 SHALL make an event visible on empty/count at the third rising clock edge at which ps2_hit is sampled high (exactly 3 cycles).
REQ-017 SHALL sample ps2_data on the event cycle; ps2_data is not synchronized.
REQ-018 SHALL run a prefix FSM with states IDLE, EXT, BRK, EXTBRK.
REQ-019 SHALL transition on byte 0xE0: any state -> EXT, nothing pushed.
REQ-020 SHALL transition on byte 0xF0: IDLE -> BRK, EXT -> EXTBRK, BRK and EXTBRK unchanged; nothing pushed.
REQ-021 SHALL treat any other byte as a code byte: push {ext, brk, byte} with ext = state in EXT/EXTBRK and brk = state in BRK/EXTBRK, then go to IDLE.
REQ-022 SHALL return the FSM to IDLE even if a code byte is dropped on a full FIFO.
REQ-023 SHALL, on rd while not empty, pop one entry: q, q_ext and q_brk show the next entry after that edge.
REQ-024 SHALL ignore rd while empty: no pointer change, no underflow.
REQ-025 SHALL, on push and pop in the same cycle while non-empty, do both and leave count unchanged.
REQ-026 SHALL, on push and rd in the same cycle while empty, perform the push only.
REQ-027 SHALL, on push while full without rd, drop the byte, set overflow, and leave count = DEPTH.
REQ-028 SHALL, on push while full with rd, perform both and leave overflow unchanged.
REQ-029 SHALL wrap pointers modulo DEPTH; count SHALL never exceed DEPTH.
REQ-030 SHALL drive q = 0, q_ext = 0, q_brk = 0 while empty.
REQ-031 SHALL give clr priority over push and rd: pointers and count to 0, overflow to 0, FSM to IDLE; any same-cycle event is discarded.

Reset
REQ-032 SHALL, on reset assertion, immediately set count = 0, empty = 1, overflow = 0, q = 0, q_ext = 0, q_brk = 0, FSM to IDLE, synchronizer and edge flops to 0.
REQ-033 SHALL NOT require the storage array contents to be reset.
REQ-034 SHALL discard any event in flight in the synchronizer when reset asserts mid-byte.

Structure
REQ-035 SHALL keep constants PFX_EXT = 8'hE0, PFX_BRK = 8'hF0 and the FSM state encodings in a shared include/package, kbd_pkg.
REQ-036 SHALL implement the synchronizer and edge detector as one sub-module, sync_edge.
REQ-037 SHALL implement storage as a DEPTH x 10-bit register array.

Verification
REQ-038 SHALL cover a basic push: hit with 0x1C -> after 3 clocks empty = 0, count = 1, q = 0x1C, q_ext = 0, q_brk = 0; rd -> empty = 1, q = 0.
REQ-039 SHALL cover prefix decoding: bytes E0, F0, 0x75 -> one entry q = 0x75, q_ext = 1, q_brk = 1; next byte 0x75 -> q_ext = 0, q_brk = 0.
REQ-040 SHALL cover overflow: 17 code bytes with no rd -> count = 16, overflow = 1, head = first byte; clr -> count = 0, overflow = 0.
REQ-041 SHALL cover simultaneous events: push with rd when count = 5 -> count = 5; push with rd when empty -> count = 1; rd when empty -> no change.
REQ-042 SHALL cover mid-operation reset: reset asserted between E0 and the code byte -> FSM in IDLE; next 0x6B stored with q_ext = 0.
REQ-043 SHALL cover wrap-around: 40 pushes interleaved with pops -> data order preserved and count consistent with a reference model.
